// File: rtl/r_chan_unpack.sv
// r_chan_unpack: pops packed R beats from the read-side FIFO into a 2-entry skid buffer and presents them as AXI R.
module r_chan_unpack #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32,
  parameter int PKT_W  = ID_W + DATA_W + 3
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [PKT_W-1:0]  fifo_rdata,
  input  logic              fifo_rempty,
  output logic              fifo_rpop,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [8:0]        beat_cnt,
  output logic              err_burst,
  output logic              err_resp,
  input  logic              err_clr
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [PKT_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [8:0]       beat_cnt_q, beat_cnt_d;
  logic             err_burst_q, err_burst_d, err_resp_q, err_resp_d;
  logic             pop, deq, wrap;
  assign RVALID    = state_q != EMPTY;
  assign RLAST     = slot0_q[0];
  assign RRESP     = slot0_q[2:1];
  assign RDATA     = slot0_q[DATA_W+2:3];
  assign RID       = slot0_q[PKT_W-1:DATA_W+3];
  assign fifo_rpop = pop;
  assign beat_cnt  = beat_cnt_q;
  assign err_burst = err_burst_q;
  assign err_resp  = err_resp_q;
  always_comb begin
    pop         = !fifo_rempty && state_q != TWO && !rrst;
    deq         = RVALID && RREADY;
    wrap        = deq && !slot0_q[0] && beat_cnt_q == 9'd255;
    state_d     = state_q == EMPTY ? (pop ? ONE : EMPTY)
                : state_q == ONE   ? ((pop && !deq) ? TWO : (!pop && deq) ? EMPTY : ONE)
                : (deq ? ONE : TWO);
    // slot0 is always the head: refill it from the FIFO or shift slot1 forward
    slot0_d     = (pop && (state_q == EMPTY || deq)) ? fifo_rdata
                : (deq && state_q == TWO) ? slot1_q : slot0_q;
    slot1_d     = (pop && !deq && state_q == ONE) ? fifo_rdata : slot1_q;
    beat_cnt_d  = !deq ? beat_cnt_q : (slot0_q[0] || wrap) ? 9'd0 : beat_cnt_q + 9'd1;
    err_burst_d = wrap ? 1'b1 : err_clr ? 1'b0 : err_burst_q;
    err_resp_d  = (deq && slot0_q[2]) ? 1'b1 : err_clr ? 1'b0 : err_resp_q;
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= EMPTY;
      slot0_q     <= '0;
      slot1_q     <= '0;
      beat_cnt_q  <= '0;
      err_burst_q <= 1'b0;
      err_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      beat_cnt_q  <= beat_cnt_d;
      err_burst_q <= err_burst_d;
      err_resp_q  <= err_resp_d;
    end
  end
endmodule

// File: tb/tb_r_chan_unpack.sv
// tb_r_chan_unpack: FIFO model plus scoreboard of FIFO input order against beats accepted on the R channel.
module tb_r_chan_unpack;
  localparam int ID_W = 8, DATA_W = 32, PKT_W = ID_W + DATA_W + 3;
  logic              rclk = 1'b0, rrst = 1'b1;
  logic [PKT_W-1:0]  fifo_rdata = '0;
  logic              fifo_rempty = 1'b1, fifo_rpop;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST, RVALID, RREADY = 1'b0;
  logic [8:0]        beat_cnt;
  logic              err_burst, err_resp, err_clr = 1'b0;
  r_chan_unpack #(.ID_W(ID_W), .DATA_W(DATA_W), .PKT_W(PKT_W)) dut (
    .rclk(rclk), .rrst(rrst), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rpop(fifo_rpop), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY), .beat_cnt(beat_cnt), .err_burst(err_burst),
    .err_resp(err_resp), .err_clr(err_clr)
  );
  always #5 rclk = ~rclk;
  logic [PKT_W-1:0] fifo_q[$], exp_q[$], prev_pkt;
  int checks = 0, errors = 0, occ = 0, pops = 0, deqs = 0, vcycles = 0;
  logic [8:0] m_cnt = '0;
  logic m_eb = 1'b0, m_er = 1'b0, prev_hold = 1'b0;
  function automatic logic [PKT_W-1:0] pk(input logic [7:0] id, input logic [31:0] d,
                                          input logic [1:0] r, input logic l);
    return {id, d, r, l};
  endfunction
  task automatic refresh();
    fifo_rempty = fifo_q.size() == 0;
    fifo_rdata  = fifo_rempty ? PKT_W'({$urandom, $urandom}) : fifo_q[0];
  endtask
  task automatic push(input logic [PKT_W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask
  // One clock: check outputs at the negedge, advance the model, then step the FIFO after the edge
  task automatic cyc();
    logic p, d, wrap;
    logic [PKT_W-1:0] cur, e;
    @(negedge rclk);
    cur = {RID, RDATA, RRESP, RLAST};
    p = fifo_rpop;
    d = RVALID && RREADY;
    checks++;
    if (p && (fifo_rempty || rrst)) begin errors++; $display("FAIL pop_guard: fifo_rpop=%b fifo_rempty=%b rrst=%b", p, fifo_rempty, rrst); end
    checks++;
    if (RVALID !== (occ != 0)) begin errors++; $display("FAIL rvalid: got %b expected %b (occ %0d)", RVALID, occ != 0, occ); end
    checks++;
    if ({beat_cnt, err_burst, err_resp} !== {m_cnt, m_eb, m_er}) begin
      errors++; $display("FAIL cnt_err: got cnt=%0d eb=%b er=%b expected cnt=%0d eb=%b er=%b", beat_cnt, err_burst, err_resp, m_cnt, m_eb, m_er);
    end
    if (prev_hold) begin
      checks++;
      if (RVALID !== 1'b1 || cur !== prev_pkt) begin errors++; $display("FAIL hold: got valid=%b pkt=%h expected valid=1 pkt=%h", RVALID, cur, prev_pkt); end
    end
    if (RVALID) vcycles++;
    if (rrst) begin
      repeat (occ) void'(exp_q.pop_front());
      occ = 0; m_cnt = '0; m_eb = 1'b0; m_er = 1'b0;
    end else begin
      wrap = 1'b0;
      if (d) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL beat: got %h expected none", cur); end
        else begin
          e = exp_q.pop_front();
          if (cur !== e) begin errors++; $display("FAIL beat: got %h expected %h", cur, e); end
        end
        wrap  = !cur[0] && m_cnt == 9'd255;
        m_cnt = (cur[0] || wrap) ? 9'd0 : m_cnt + 9'd1;
        deqs++;
      end
      m_eb = wrap ? 1'b1 : err_clr ? 1'b0 : m_eb;
      m_er = (d && cur[2]) ? 1'b1 : err_clr ? 1'b0 : m_er;
      occ  = occ + int'(p) - int'(d);
      checks++;
      if (occ > 2 || occ < 0) begin errors++; $display("FAIL occupancy: got %0d expected 0..2", occ); end
    end
    if (p) pops++;
    prev_hold = RVALID && !d && !rrst;
    prev_pkt  = cur;
    @(posedge rclk);
    #1;
    if (p) void'(fifo_q.pop_front());
    refresh();
  endtask
  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || occ != 0) && n < bound) begin cyc(); n++; end
    checks++;
    if (exp_q.size() != 0 || occ != 0) begin errors++; $display("FAIL drain: got %0d beats left expected 0 within %0d cycles", exp_q.size() + occ, bound); end
  endtask
  task automatic test_reset();
    checks++;
    if ({RVALID, RID, RDATA, RRESP, RLAST, beat_cnt, err_burst, err_resp, fifo_rpop} !== '0) begin
      errors++; $display("FAIL reset: got valid=%b id=%h data=%h resp=%b last=%b cnt=%0d eb=%b er=%b pop=%b expected all 0",
                         RVALID, RID, RDATA, RRESP, RLAST, beat_cnt, err_burst, err_resp, fifo_rpop);
    end
    cyc();
    rrst = 1'b0;
  endtask
  task automatic test_single();
    RREADY = 1'b1;
    push(pk(8'h3, 32'hDEADBEEF, 2'b00, 1'b1));
    #1;
    checks++;
    if (fifo_rpop !== 1'b1) begin errors++; $display("FAIL single_pop: got %b expected 1", fifo_rpop); end
    cyc();
    checks++;
    if ({RVALID, RID, RDATA, RLAST} !== {1'b1, 8'h3, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL single_beat: got valid=%b id=%h data=%h last=%b expected 1/03/deadbeef/1", RVALID, RID, RDATA, RLAST);
    end
    cyc();
    checks++;
    if ({RVALID, beat_cnt, fifo_rpop} !== 11'b0) begin errors++; $display("FAIL single_done: got valid=%b cnt=%0d pop=%b expected 0/0/0", RVALID, beat_cnt, fifo_rpop); end
  endtask
  task automatic test_burst();
    int d0;
    RREADY = 1'b1;
    d0 = deqs;
    vcycles = 0;
    for (int i = 0; i < 8; i++) push(pk(8'(16 + i), 32'(32'h1000 + i), 2'b00, i == 7));
    drain(40);
    checks++;
    if (deqs - d0 != 8 || vcycles != 8) begin errors++; $display("FAIL burst: got %0d beats in %0d valid cycles expected 8 in 8", deqs - d0, vcycles); end
  endtask
  task automatic test_backpressure();
    int p0;
    RREADY = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) push(pk(8'(32 + i), 32'(32'h2000 + i), 2'b01, i == 4));
    repeat (6) cyc();
    checks++;
    if (pops - p0 != 2 || occ != 2 || fifo_rpop !== 1'b0 || RID !== 8'd32) begin
      errors++; $display("FAIL backpressure: got pops=%0d occ=%0d rpop=%b id=%h expected 2/2/0/20", pops - p0, occ, fifo_rpop, RID);
    end
    RREADY = 1'b1;
    drain(40);
  endtask
  task automatic test_alternate();
    for (int i = 0; i < 80; i++) begin
      RREADY = (i % 2) == 1;
      if ($urandom_range(0, 1) == 1) push(pk(8'($urandom), $urandom, 2'($urandom_range(0, 1)), 1'($urandom)));
      cyc();
    end
    RREADY = 1'b1;
    push(pk(8'hEE, 32'h0, 2'b00, 1'b1));
    drain(200);
  endtask
  task automatic test_errors();
    RREADY = 1'b1;
    for (int i = 0; i < 256; i++) push(pk(8'hA, 32'(i), 2'b00, 1'b0));
    drain(600);
    checks++;
    if (err_burst !== 1'b1 || beat_cnt !== 9'd0) begin errors++; $display("FAIL err_burst: got eb=%b cnt=%0d expected 1/0", err_burst, beat_cnt); end
    push(pk(8'h1, 32'h1, 2'b10, 1'b1));
    drain(20);
    checks++;
    if (err_resp !== 1'b1) begin errors++; $display("FAIL err_resp: got %b expected 1", err_resp); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++;
    if ({err_burst, err_resp} !== 2'b00) begin errors++; $display("FAIL err_clr: got eb=%b er=%b expected 0/0", err_burst, err_resp); end
    RREADY = 1'b0;
    push(pk(8'h2, 32'h2, 2'b11, 1'b1));
    repeat (2) cyc();
    RREADY = 1'b1;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++;
    if (err_resp !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got er=%b expected 1", err_resp); end
    drain(20);
  endtask
  task automatic test_reset_two();
    RREADY = 1'b1;
    push(pk(8'h5, 32'h5, 2'b10, 1'b0));
    drain(20);
    RREADY = 1'b0;
    for (int i = 0; i < 3; i++) push(pk(8'(64 + i), 32'(32'h3000 + i), 2'b00, 1'b1));
    repeat (3) cyc();
    checks++;
    if (occ != 2 || fifo_rempty !== 1'b0 || err_resp !== 1'b1 || beat_cnt !== 9'd1) begin
      errors++; $display("FAIL pre_reset: got occ=%0d empty=%b er=%b cnt=%0d expected 2/0/1/1", occ, fifo_rempty, err_resp, beat_cnt);
    end
    rrst = 1'b1;
    #1;
    checks++;
    if (fifo_rpop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", fifo_rpop); end
    cyc();
    rrst = 1'b0;
    checks++;
    if ({RVALID, beat_cnt, err_burst, err_resp} !== 12'b0) begin
      errors++; $display("FAIL mid_reset: got valid=%b cnt=%0d eb=%b er=%b expected all 0", RVALID, beat_cnt, err_burst, err_resp);
    end
    RREADY = 1'b1;
    drain(20);
  endtask
  initial begin
    refresh();
    @(posedge rclk);
    #1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_alternate();
    test_errors();
    test_reset_two();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
